// File: rtl/snake_autopilot.sv
// Snake autoplayer: steers the head toward the apple through active-low keys and restarts after death.
// Latency: a key asserts two edges after stall is first sampled and is held for HOLD_CYCLES cycles; restart key one edge after death_stall.
// Backpressure: one decision per stall episode; holds in RELEASE/REST_REL until the game drops stall/death_end.
module snake_autopilot #(
   parameter int HOLD_CYCLES = 8,
   parameter int GRID_MAX    = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       stall,
   input  logic       death_stall,
   input  logic       death_end,
   input  logic [7:0] head,
   input  logic [7:0] apple,
   input  logic [3:0] dir,
   output logic [3:0] key_n,
   output logic       busy,
   output logic [7:0] moves
);

   // One-hot key encodings, bit order {LEFT,UP,DOWN,RIGHT}
   localparam logic [3:0] K_LEFT  = 4'b1000;
   localparam logic [3:0] K_UP    = 4'b0100;
   localparam logic [3:0] K_DOWN  = 4'b0010;
   localparam logic [3:0] K_RIGHT = 4'b0001;
   localparam logic [3:0] K_NONE  = 4'b0000;

   localparam logic [3:0] GMAX      = 4'(GRID_MAX);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_OFF,
      S_WAIT,
      S_DECIDE,
      S_PRESS,
      S_RELEASE,
      S_RESTART,
      S_REST_REL
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] k_q, k_d;
   logic [7:0] moves_q, moves_d;
   logic [3:0] key_n_q, key_n_d;
   logic       busy_q, busy_d;

   logic [3:0] hx, hy, ax, ay;
   logic [3:0] pref_key;
   logic [3:0] rev_dir;
   logic [3:0] choice_key;
   logic       skip_press;

   // Steering choice: close x first, then y; never reverse onto the body
   always_comb begin
      hx         = head[3:0];
      hy         = head[7:4];
      ax         = apple[3:0];
      ay         = apple[7:4];
      pref_key   = K_NONE;
      choice_key = K_NONE;
      // Reversing {L,U,D,R} is a bit reversal: LEFT<->RIGHT, UP<->DOWN
      rev_dir    = {dir[0], dir[1], dir[2], dir[3]};

      if (ax > hx) begin
         pref_key = K_RIGHT;
      end else if (ax < hx) begin
         pref_key = K_LEFT;
      end else if (ay > hy) begin
         pref_key = K_DOWN;
      end else if (ay < hy) begin
         pref_key = K_UP;
      end

      choice_key = pref_key;
      if ((pref_key != K_NONE) && (pref_key == rev_dir)) begin
         if (pref_key[3] || pref_key[0]) begin
            // Horizontal reversal: dodge vertically, staying inside the grid
            choice_key = (hy < GMAX) ? K_DOWN : K_UP;
         end else begin
            // Vertical reversal: dodge horizontally, staying inside the grid
            choice_key = (hx < GMAX) ? K_RIGHT : K_LEFT;
         end
      end

      skip_press = (head == apple) || (choice_key == dir);
   end

   // Next state and next registered outputs; outputs follow the current state one edge later
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      moves_d = moves_q;
      key_n_d = 4'b1111;

      case (state_q)
         S_OFF: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (death_stall) begin
               state_d = S_RESTART;
            end else if (stall) begin
               state_d = S_DECIDE;
            end
         end
         S_DECIDE: begin
            k_d     = choice_key;
            cnt_d   = 8'd0;
            state_d = skip_press ? S_RELEASE : S_PRESS;
         end
         S_PRESS: begin
            key_n_d = ~k_q;
            if (cnt_q == 8'd0) begin
               moves_d = moves_q + 8'd1;
            end
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RELEASE: begin
            if (death_stall) begin
               state_d = S_RESTART;
            end else if (!stall) begin
               state_d = S_WAIT;
            end
         end
         S_RESTART: begin
            key_n_d = ~K_DOWN;
            if (death_end) begin
               state_d = S_REST_REL;
            end
         end
         S_REST_REL: begin
            if (!death_end) begin
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d = S_OFF;
         end
      endcase

      // Disable wins from any state and releases keys on the very next edge
      if (!en) begin
         state_d = S_OFF;
         cnt_d   = 8'd0;
         moves_d = moves_q;
         key_n_d = 4'b1111;
      end

      busy_d = (key_n_d != 4'b1111);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_OFF;
         cnt_q   <= 8'd0;
         k_q     <= K_NONE;
         moves_q <= 8'd0;
         key_n_q <= 4'b1111;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         moves_q <= moves_d;
         key_n_q <= key_n_d;
         busy_q  <= busy_d;
      end
   end

   assign key_n = key_n_q;
   assign busy  = busy_q;
   assign moves = moves_q;

endmodule

// File: tb/tb_snake_autopilot.sv
// Directed bench for snake_autopilot with a scoreboard of expected output samples.
// Expected key_n/busy/moves values are queued when stimulus is driven and popped when sampled.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_snake_autopilot;

   localparam int HOLD = 8;

   localparam logic [3:0] KN_NONE  = 4'b1111;
   localparam logic [3:0] KN_LEFT  = 4'b0111;
   localparam logic [3:0] KN_UP    = 4'b1011;
   localparam logic [3:0] KN_DOWN  = 4'b1101;
   localparam logic [3:0] KN_RIGHT = 4'b1110;

   localparam logic [3:0] D_LEFT  = 4'b1000;
   localparam logic [3:0] D_UP    = 4'b0100;
   localparam logic [3:0] D_DOWN  = 4'b0010;
   localparam logic [3:0] D_RIGHT = 4'b0001;

   logic       clk = 1'b0;
   logic       rst, en, stall, death_stall, death_end;
   logic [7:0] head, apple;
   logic [3:0] dir;
   logic [3:0] key_n;
   logic       busy;
   logic [7:0] moves;

   string       tag_q[$];
   logic [15:0] val_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_moves = 8'd0;
   int          low_cnt;

   snake_autopilot #(
      .HOLD_CYCLES(HOLD),
      .GRID_MAX   (15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .stall      (stall),
      .death_stall(death_stall),
      .death_end  (death_end),
      .head       (head),
      .apple      (apple),
      .dir        (dir),
      .key_n      (key_n),
      .busy       (busy),
      .moves      (moves)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [15:0] v);
      tag_q.push_back(tag);
      val_q.push_back(v);
   endtask

   task automatic check(input logic [15:0] obs);
      string       t;
      logic [15:0] v;
      n_cmp++;
      if (val_q.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
      end else begin
         t = tag_q.pop_front();
         v = val_q.pop_front();
         assert (obs === v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", t, obs, v);
         end
      end
   endtask

   // One stall pulse from WAIT; kn is the expected key_n (KN_NONE when no press is needed)
   task automatic press(input string tag, input logic [7:0] h, input logic [7:0] a,
                        input logic [3:0] d, input logic [3:0] kn);
      head  = h;
      apple = a;
      dir   = d;
      stall = 1'b1;
      expect_val({tag, "_decide"}, 16'(KN_NONE));
      if (kn != KN_NONE) begin
         exp_moves = exp_moves + 8'd1;
         expect_val({tag, "_key0"}, 16'(kn));
         expect_val({tag, "_moves_edge"}, 16'(exp_moves));
         expect_val({tag, "_busy"}, 16'(1'b1));
         for (int i = 1; i < HOLD; i++) expect_val({tag, "_hold"}, 16'(kn));
      end
      expect_val({tag, "_release"}, 16'(KN_NONE));
      expect_val({tag, "_moves"}, 16'(exp_moves));

      step(1);            // edge N samples stall
      stall = 1'b0;
      step(1);            // edge N+1: still released
      check(16'(key_n));
      if (kn != KN_NONE) begin
         step(1);         // edge N+2: key asserts with moves update
         check(16'(key_n));
         check(16'(moves));
         check(16'(busy));
         for (int i = 1; i < HOLD; i++) begin
            step(1);
            check(16'(key_n));
         end
      end
      step(1);
      check(16'(key_n));
      check(16'(moves));
      step(1);
   endtask

   task automatic fast_press();
      head  = 8'h32;
      apple = 8'h37;
      dir   = D_UP;
      stall = 1'b1;
      step(1);
      stall = 1'b0;
      step(HOLD + 3);
      exp_moves = exp_moves + 8'd1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; stall = 1'b0; death_stall = 1'b0; death_end = 1'b0;
      head = 8'h00; apple = 8'h00; dir = D_RIGHT;

      // Reset state
      expect_val("rst_key_n", 16'(KN_NONE));
      expect_val("rst_busy", 16'(1'b0));
      expect_val("rst_moves", 16'(8'd0));
      step(2);
      check(16'(key_n));
      check(16'(busy));
      check(16'(moves));
      rst = 1'b0;
      en  = 1'b1;
      step(2);

      // X correction: already heading toward apple, then a needed turn
      press("x_same_dir", 8'h32, 8'h37, D_RIGHT, KN_NONE);
      press("x_turn",     8'h32, 8'h37, D_UP,    KN_RIGHT);

      // Reversal substitution, including grid edges
      press("rev_h_down", 8'h55, 8'h51, D_RIGHT, KN_DOWN);
      press("rev_h_up",   8'hF5, 8'hF1, D_RIGHT, KN_UP);
      press("rev_v_left", 8'h5F, 8'h2F, D_DOWN,  KN_LEFT);
      press("rev_v_right",8'h53, 8'h23, D_DOWN,  KN_RIGHT);

      // Y correction and apple reached
      press("y_down",     8'h24, 8'h94, D_LEFT,  KN_DOWN);
      press("y_up",       8'h94, 8'h24, D_LEFT,  KN_UP);
      press("on_apple",   8'h44, 8'h44, D_UP,    KN_NONE);

      // Held stall: exactly one press
      head = 8'h32; apple = 8'h37; dir = D_UP; stall = 1'b1;
      exp_moves = exp_moves + 8'd1;
      expect_val("held_low_cycles", 16'(HOLD));
      expect_val("held_moves", 16'(exp_moves));
      low_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (key_n != KN_NONE) low_cnt++;
      end
      stall = 1'b0;
      step(2);
      check(16'(low_cnt));
      check(16'(moves));

      // Death together with stall: restart key wins
      stall = 1'b1; death_stall = 1'b1;
      expect_val("death_m0", 16'(KN_NONE));
      expect_val("death_key", 16'(KN_DOWN));
      expect_val("death_busy", 16'(1'b1));
      for (int i = 0; i < 3; i++) expect_val("death_hold", 16'(KN_DOWN));
      expect_val("death_end_edge", 16'(KN_DOWN));
      expect_val("death_release", 16'(KN_NONE));
      expect_val("death_rel_busy", 16'(1'b0));
      expect_val("death_moves", 16'(exp_moves));
      step(1);
      check(16'(key_n));
      step(1);
      check(16'(key_n));
      check(16'(busy));
      for (int i = 0; i < 3; i++) begin
         step(1);
         check(16'(key_n));
      end
      death_end = 1'b1;
      step(1);
      check(16'(key_n));
      step(1);
      check(16'(key_n));
      check(16'(busy));
      death_stall = 1'b0; stall = 1'b0; death_end = 1'b0;
      step(2);
      check(16'(moves));
      press("after_death", 8'h24, 8'h94, D_LEFT, KN_DOWN);

      // Reset in the middle of a press
      head = 8'h32; apple = 8'h37; dir = D_UP; stall = 1'b1;
      expect_val("mid_press_key", 16'(KN_RIGHT));
      expect_val("rst_mid_key_n", 16'(KN_NONE));
      expect_val("rst_mid_busy", 16'(1'b0));
      expect_val("rst_mid_moves", 16'(8'd0));
      step(1);
      stall = 1'b0;
      step(3);
      check(16'(key_n));
      rst = 1'b1;
      step(1);
      check(16'(key_n));
      check(16'(busy));
      check(16'(moves));
      exp_moves = 8'd0;
      rst = 1'b0;
      step(2);

      // 256 presses wrap the move counter
      for (int i = 0; i < 255; i++) fast_press();
      expect_val("moves_255", 16'(8'd255));
      check(16'(moves));
      fast_press();
      expect_val("moves_wrap", 16'(8'd0));
      check(16'(moves));

      // Enable dropped mid-press: keys released next edge, moves kept
      head = 8'h32; apple = 8'h37; dir = D_UP; stall = 1'b1;
      exp_moves = exp_moves + 8'd1;
      expect_val("en_mid_key", 16'(KN_RIGHT));
      expect_val("en_off_key_n", 16'(KN_NONE));
      expect_val("en_off_busy", 16'(1'b0));
      expect_val("en_off_moves", 16'(exp_moves));
      expect_val("en_off_stays", 16'(KN_NONE));
      step(1);
      stall = 1'b0;
      step(3);
      check(16'(key_n));
      en = 1'b0;
      step(1);
      check(16'(key_n));
      check(16'(busy));
      check(16'(moves));
      step(3);
      check(16'(key_n));
      en = 1'b1;
      step(2);
      press("resume", 8'h94, 8'h24, D_RIGHT, KN_UP);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
